flt2int_seq: RTL and testbench

Parametrised multi-cycle converter from IEEE-style binary float (sign/biased exponent/fraction) to a signed two's-complement integer, with start/done handshake. Generalises the fixed half-precision, truncate-only float-to-int operation to arbitrary exponent, fraction and integer widths. Adds saturation and inexact status flags, plus optional round-half-to-even. Used as a hardware reference or accelerator alongside the program-2 float/int routines.

---
 rtl/flt2int_pkg.sv | 28 ++
 rtl/f2i_round_pack.sv | 52 +++++
 rtl/flt2int_seq.sv | 196 +++++++++++++++++++
 tb/tb_flt2int_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flt2int_pkg.sv
// Shared types and parameter-derived constants for the float-to-integer converter.
package flt2int_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClassify,
        StShift,
        StFinish,
        StDone
    } f2i_state_e;

    function automatic int unsigned f2i_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    function automatic longint f2i_int_max(input int unsigned int_w);
        return (64'sd1 <<< (int_w - 32'd1)) - 64'sd1;
    endfunction

    function automatic longint f2i_int_min(input int unsigned int_w);
        return -(64'sd1 <<< (int_w - 32'd1));
    endfunction

    function automatic int unsigned f2i_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/f2i_round_pack.sv
// Final magnitude-to-signed-integer packing with saturation; round-half-to-even is
// built only when FLT2INT_ROUND_EN is defined, otherwise the magnitude is truncated.
module f2i_round_pack
    import flt2int_pkg::*;
#(
    parameter int unsigned INT_W = 16,
    parameter int unsigned ACC_W = 17
) (
    input  logic [ACC_W-1:0] mag_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic             sign_i,
    output logic [INT_W-1:0] int_o,
    output logic             ovf_o,
    output logic             inexact_o
);

    localparam logic [INT_W-1:0] IntMax = INT_W'(f2i_int_max(INT_W));
    localparam logic [INT_W-1:0] IntMin = INT_W'(f2i_int_min(INT_W));
    // Largest magnitudes representable for negative and positive results.
    localparam logic [ACC_W:0]   NegLim = (ACC_W + 1)'(1) << (INT_W - 1);
    localparam logic [ACC_W:0]   PosLim = NegLim - (ACC_W + 1)'(1);

    logic [ACC_W:0] mag_r;

    always_comb begin
`ifdef FLT2INT_ROUND_EN
        mag_r = {1'b0, mag_i} + (ACC_W + 1)'(guard_i & (sticky_i | mag_i[0]));
`else
        mag_r = {1'b0, mag_i};
`endif
        inexact_o = guard_i | sticky_i;
        ovf_o     = 1'b0;
        int_o     = '0;
        if (sign_i) begin
            if (mag_r > NegLim) begin
                int_o = IntMin;
                ovf_o = 1'b1;
            end else begin
                int_o = ~mag_r[INT_W-1:0] + INT_W'(1);
            end
        end else begin
            if (mag_r > PosLim) begin
                int_o = IntMax;
                ovf_o = 1'b1;
            end else begin
                int_o = mag_r[INT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/flt2int_seq.sv
// Multi-cycle float {sign, exp, frac} to signed integer converter with start/done handshake.
// Define FLT2INT_ROUND_EN for round-half-to-even; default build truncates toward zero.
module flt2int_seq
    import flt2int_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned INT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   flt_in,
    output logic                   busy,
    output logic                   done,
    output logic [INT_W-1:0]       int_out,
    output logic                   ovf,
    output logic                   inexact
);

    localparam int unsigned FltW     = 1 + EXP_W + MAN_W;
    // Wide enough for the result plus headroom, and for the full significand.
    localparam int unsigned AccW     = f2i_max(INT_W + 1, MAN_W + 1);
    localparam int unsigned CntW     = $clog2(INT_W + MAN_W + 3);
    localparam int unsigned Bias     = f2i_bias(EXP_W);
    localparam int unsigned SatThr   = Bias + INT_W - 2;
    localparam int unsigned LeftThr  = Bias + MAN_W;
    localparam int unsigned RightCap = MAN_W + 2;

    localparam logic [INT_W-1:0] IntMax = INT_W'(f2i_int_max(INT_W));
    localparam logic [INT_W-1:0] IntMin = INT_W'(f2i_int_min(INT_W));

    f2i_state_e        state_q, state_d;
    logic [FltW-1:0]   flt_q, flt_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              sat_q, sat_d;
    logic [INT_W-1:0]  int_out_q, int_out_d;
    logic              ovf_q, ovf_d;
    logic              inexact_q, inexact_d;

    logic              sign_w;
    logic [EXP_W-1:0]  exp_w;
    logic [MAN_W-1:0]  frac_w;
    logic [31:0]       exp_ext;
    logic [31:0]       k_left;
    logic [31:0]       k_right;

    logic [INT_W-1:0]  rp_int;
    logic              rp_ovf;
    logic              rp_inexact;

    assign sign_w  = flt_q[FltW-1];
    assign exp_w   = flt_q[FltW-2 -: EXP_W];
    assign frac_w  = flt_q[MAN_W-1:0];
    assign exp_ext = 32'(exp_w);

    always_comb begin
        k_left  = exp_ext - LeftThr;
        k_right = LeftThr - exp_ext;
        // Beyond this distance every significand bit is already in sticky.
        if (k_right > RightCap) begin
            k_right = RightCap;
        end
    end

    f2i_round_pack #(
        .INT_W (INT_W),
        .ACC_W (AccW)
    ) u_round_pack (
        .mag_i     (acc_q),
        .guard_i   (guard_q),
        .sticky_i  (sticky_q),
        .sign_i    (sign_w),
        .int_o     (rp_int),
        .ovf_o     (rp_ovf),
        .inexact_o (rp_inexact)
    );

    always_comb begin
        state_d   = state_q;
        flt_d     = flt_q;
        acc_d     = acc_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        sat_d     = sat_q;
        int_out_d = int_out_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    flt_d   = flt_in;
                    state_d = StClassify;
                end
            end

            StClassify: begin
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                sat_d    = 1'b0;
                acc_d    = '0;
                cnt_d    = '0;
                left_d   = 1'b0;
                if (exp_w == '0) begin
                    // Zero and subnormals: zero magnitude, fraction only feeds inexact.
                    sticky_d = |frac_w;
                    state_d  = StFinish;
                end else if (exp_w == '1 || exp_ext > SatThr) begin
                    sat_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    acc_d = AccW'({1'b1, frac_w});
                    if (exp_ext >= LeftThr) begin
                        left_d  = 1'b1;
                        cnt_d   = CntW'(k_left);
                        state_d = (k_left == 32'd0) ? StFinish : StShift;
                    end else begin
                        cnt_d   = CntW'(k_right);
                        state_d = StShift;
                    end
                end
            end

            StShift: begin
                cnt_d = cnt_q - CntW'(1);
                if (left_q) begin
                    acc_d = acc_q << 1;
                end else begin
                    acc_d    = acc_q >> 1;
                    guard_d  = acc_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                if (cnt_q == CntW'(1)) begin
                    state_d = StFinish;
                end
            end

            StFinish: begin
                state_d = StDone;
                if (sat_q) begin
                    int_out_d = sign_w ? IntMin : IntMax;
                    ovf_d     = 1'b1;
                    inexact_d = 1'b0;
                end else begin
                    int_out_d = rp_int;
                    ovf_d     = rp_ovf;
                    inexact_d = rp_inexact;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            flt_q     <= '0;
            acc_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            sat_q     <= 1'b0;
            int_out_q <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flt_q     <= flt_d;
            acc_q     <= acc_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            sat_q     <= sat_d;
            int_out_q <= int_out_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
        end
    end

    assign busy    = (state_q == StClassify) || (state_q == StShift) || (state_q == StFinish);
    assign done    = (state_q == StDone);
    assign int_out = int_out_q;
    assign ovf     = ovf_q;
    assign inexact = inexact_q;

endmodule

// File: tb/tb_flt2int_seq.sv
// Scoreboard bench for flt2int_seq: half-precision and single-precision instances
// checked against an arithmetic reference model, including latency in clock edges.
module tb_flt2int_seq;

`ifdef FLT2INT_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    typedef struct {
        longint res;
        bit     ovf;
        bit     inx;
        int     lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] flt_in;
    logic        busy, done, ovf, inexact;
    logic [15:0] int_out;
    logic        start32;
    logic [31:0] flt32;
    logic        busy32, done32, ovf32, inexact32;
    logic [31:0] int_out32;

    always #5 clk = ~clk;

    flt2int_seq #(
        .EXP_W (5),
        .MAN_W (10),
        .INT_W (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flt_in  (flt_in),
        .busy    (busy),
        .done    (done),
        .int_out (int_out),
        .ovf     (ovf),
        .inexact (inexact)
    );

    flt2int_seq #(
        .EXP_W (8),
        .MAN_W (23),
        .INT_W (32)
    ) dut32 (
        .clk     (clk),
        .reset   (reset),
        .start   (start32),
        .flt_in  (flt32),
        .busy    (busy32),
        .done    (done32),
        .int_out (int_out32),
        .ovf     (ovf32),
        .inexact (inexact32)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the significand with a remainder test.
    function automatic void model(input longint f, input int ew, input int mw, input int iw,
                                  output longint res, output bit ovf_e, output bit inx_e,
                                  output int lat);
        longint sgn, expf, frac, sig, mag, rem, half, maxpos, negmag;
        int     e, sh;
        sgn    = (f >>> (ew + mw)) & 64'sd1;
        expf   = (f >>> mw) & ((64'sd1 <<< ew) - 1);
        frac   = f & ((64'sd1 <<< mw) - 1);
        e      = int'(expf) - ((1 << (ew - 1)) - 1);
        maxpos = (64'sd1 <<< (iw - 1)) - 1;
        negmag = maxpos + 1;
        res    = 0;
        ovf_e  = 1'b0;
        inx_e  = 1'b0;
        lat    = 2;
        if (expf == 0) begin
            inx_e = (frac != 0);
        end else if (expf == (64'sd1 <<< ew) - 1 || e > iw - 2) begin
            ovf_e = 1'b1;
            res   = (sgn != 0) ? -negmag : maxpos;
        end else begin
            sig = (64'sd1 <<< mw) | frac;
            if (e >= mw) begin
                mag = sig <<< (e - mw);
                lat = 2 + e - mw;
            end else begin
                sh  = mw - e;
                lat = 2 + ((sh > mw + 2) ? mw + 2 : sh);
                if (sh >= 62) begin
                    mag   = 0;
                    inx_e = 1'b1;
                end else begin
                    mag   = sig >>> sh;
                    rem   = sig & ((64'sd1 <<< sh) - 1);
                    half  = 64'sd1 <<< (sh - 1);
                    inx_e = (rem != 0);
                    if (RoundEn && (rem > half || (rem == half && (mag & 1) != 0))) mag++;
                end
            end
            if (sgn != 0) begin
                if (mag > negmag) begin
                    ovf_e = 1'b1;
                    res   = -negmag;
                end else begin
                    res = -mag;
                end
            end else if (mag > maxpos) begin
                ovf_e = 1'b1;
                res   = maxpos;
            end else begin
                res = mag;
            end
        end
    endfunction

    task automatic push(input int which, input logic [63:0] f);
        exp_t x;
        if (which == 0) model(longint'(f[15:0]), 5, 10, 16, x.res, x.ovf, x.inx, x.lat);
        else            model(longint'(f[31:0]), 8, 23, 32, x.res, x.ovf, x.inx, x.lat);
        sb_q.push_back(x);
    endtask

    task automatic drive(input int which, input logic [63:0] f, input bit s);
        if (which == 0) begin
            start  = s;
            flt_in = f[15:0];
        end else begin
            start32 = s;
            flt32   = f[31:0];
        end
    endtask

    task automatic wait_done(input int which, input bit disturb, input logic [63:0] alt,
                             output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        while (!ok && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            ok = (which == 0) ? done : done32;
            if (!ok && disturb) begin
                if (edges == 2)      drive(which, alt, 1'b1);
                else if (edges == 3) drive(which, alt, 1'b0);
            end
        end
    endtask

    task automatic check_result(input int which, input string tag, input int edges,
                                input bit ok);
        exp_t   x;
        longint got_int;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard"}, 0, 1);
            return;
        end
        x = sb_q.pop_front();
        got_int = (which == 0) ? longint'($signed(int_out)) : longint'($signed(int_out32));
        check({tag, " done"}, longint'(ok), 1);
        check({tag, " latency"}, longint'(edges), longint'(x.lat));
        check({tag, " int_out"}, got_int, x.res);
        check({tag, " ovf"}, longint'((which == 0) ? ovf : ovf32), longint'(x.ovf));
        check({tag, " inexact"}, longint'((which == 0) ? inexact : inexact32),
              longint'(x.inx));
        check({tag, " busy"}, longint'((which == 0) ? busy : busy32), 0);
    endtask

    task automatic run_op(input int which, input logic [63:0] f, input string tag,
                          input bit disturb);
        int edges;
        bit ok;
        push(which, f);
        drive(which, f, 1'b1);
        @(posedge clk);
        #1;
        drive(which, f, 1'b0);
        wait_done(which, disturb, ~f, edges, ok);
        check_result(which, tag, edges, ok);
    endtask

    initial begin
        int edges;
        bit ok;
        reset   = 1'b1;
        start   = 1'b0;
        start32 = 1'b0;
        flt_in  = '0;
        flt32   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check("reset int_out", longint'(int_out), 0);
        check("reset ovf", longint'(ovf), 0);
        check("reset inexact", longint'(inexact), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(0, 64'h3C00, "one", 1'b0);
        run_op(0, 64'h4B00, "fourteen", 1'b0);
        run_op(0, 64'hCB00, "neg_fourteen", 1'b0);
        run_op(0, 64'hF780, "neg_30720", 1'b0);
        run_op(0, 64'h7B80, "sat_pos", 1'b0);
        run_op(0, 64'hF800, "sat_neg_edge", 1'b0);
        run_op(0, 64'h77FF, "max_in_range", 1'b0);
        run_op(0, 64'h3E00, "one_half_pos", 1'b0);
        run_op(0, 64'hBE00, "one_half_neg", 1'b0);
        run_op(0, 64'h4100, "two_half", 1'b0);
        run_op(0, 64'h3800, "half", 1'b0);
        run_op(0, 64'h3400, "quarter", 1'b0);
        run_op(0, 64'h2C00, "tiny", 1'b0);
        run_op(0, 64'h8000, "neg_zero", 1'b0);
        run_op(0, 64'h0001, "subnormal", 1'b0);
        run_op(0, 64'h7C00, "pos_inf", 1'b0);
        run_op(0, 64'hFC00, "neg_inf", 1'b0);
        run_op(0, 64'h3C00, "busy_start_ignored", 1'b1);

        // Start held high through busy and into DONE relaunches immediately.
        push(0, 64'h4B00);
        drive(0, 64'h4B00, 1'b1);
        @(posedge clk);
        #1;
        wait_done(0, 1'b0, 64'h0, edges, ok);
        check_result(0, "hold_first", edges, ok);
        push(0, 64'hC100);
        drive(0, 64'hC100, 1'b1);
        @(posedge clk);
        #1;
        check("hold done dropped", longint'(done), 0);
        check("hold busy", longint'(busy), 1);
        drive(0, 64'hC100, 1'b0);
        wait_done(0, 1'b0, 64'h0, edges, ok);
        check_result(0, "hold_second", edges, ok);

        // Reset in the middle of a long shift clears everything without a clock edge.
        run_op(0, 64'h3E00, "pre_reset", 1'b0);
        drive(0, 64'h3C00, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 64'h3C00, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset busy", longint'(busy), 0);
        check("midreset done", longint'(done), 0);
        check("midreset int_out", longint'(int_out), 0);
        check("midreset ovf", longint'(ovf), 0);
        check("midreset inexact", longint'(inexact), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op(0, 64'h4B00, "post_reset", 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op(0, 64'($urandom_range(0, 16'hFFFF)), $sformatf("rand16_%0d", i), 1'b0);
        end

        run_op(1, 64'h4B000001, "sp_8388609", 1'b0);
        run_op(1, 64'hCF000000, "sp_int_min", 1'b0);
        run_op(1, 64'h4F000000, "sp_sat_pos", 1'b0);
        run_op(1, 64'h3FC00000, "sp_one_half", 1'b0);
        run_op(1, 64'hC0200000, "sp_neg_two_half", 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(1, 64'($urandom()), $sformatf("rand32_%0d", i), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
